// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback and drives every datapath select and write enable.
module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   supported;

    assign supported = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                       (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if      (opcode == OP_LW || opcode == OP_SW) state_d = MEM_ADDR;
                else if (opcode == OP_RTYPE)                 state_d = EXECUTE;
                else if (opcode == OP_BEQ)                   state_d = BRANCH;
                else if (opcode == OP_J)                     state_d = JUMP;
                else if (opcode == OP_ADDI)                  state_d = ADDI_EX;
                else                                         state_d = FETCH;
            end
            MEM_ADDR:  state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   state_d = R_WB;
            ADDI_EX:   state_d = ADDI_WB;
            default:   state_d = FETCH;
        endcase
    end

    // Reset gates every output so an interrupted instruction cannot write.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        aluop         = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        state         = '0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !supported;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    aluop     = 2'b10;
                end
                R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    aluop         = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDI_WB: begin
                    reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
